usb_link_fsm: RTL and testbench

USB_LINK_FSM -- requirements
Module: usb_link_fsm

---
 rtl/usb_link_if.sv | 41 ++++
 rtl/usb_link_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_usb_link_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_link_if.sv
// USB link-layer control bundle between packet engines and the link FSM.
// slave = the FSM side (consumes events, drives enables/pulses); master = the driving side.
interface usb_link_if #(
    parameter int TIMER_W = 16,
    parameter int DELAY_W = 6
);
    logic               ms;
    logic               rx_pid_en;
    logic [3:0]         rx_pid;
    logic               rx_sop_en;
    logic               rx_eop_en;
    logic               tx_pid_en;
    logic [3:0]         tx_pid;
    logic               tx_eop_en;
    logic [TIMER_W-1:0] time_threshold;
    logic [DELAY_W-1:0] delay_threshold;

    logic               rx_data_on;
    logic               rx_hs_on;
    logic               tx_data_on;
    logic               d_oe;
    logic               time_out;
    logic               retry_req;
    logic               xfer_done;
    logic               xfer_err;
    logic [2:0]         state_o;

    modport slave (
        input  ms, rx_pid_en, rx_pid, rx_sop_en, rx_eop_en,
        input  tx_pid_en, tx_pid, tx_eop_en, time_threshold, delay_threshold,
        output rx_data_on, rx_hs_on, tx_data_on, d_oe,
        output time_out, retry_req, xfer_done, xfer_err, state_o
    );

    modport master (
        output ms, rx_pid_en, rx_pid, rx_sop_en, rx_eop_en,
        output tx_pid_en, tx_pid, tx_eop_en, time_threshold, delay_threshold,
        input  rx_data_on, rx_hs_on, tx_data_on, d_oe,
        input  time_out, retry_req, xfer_done, xfer_err, state_o
    );
endinterface

// File: rtl/usb_link_fsm.sv
// USB link transaction sequencer (master/slave) with bus turnaround, response timer and retry.
// Enables are decoded from the state register; event pulses appear one cycle after their trigger; no backpressure.
module usb_link_fsm #(
    parameter int TIMER_W   = 16,
    parameter int DELAY_W   = 6,
    parameter int MAX_RETRY = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    usb_link_if.slave lnk
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_TOKEN  = 3'd1,
        TX_DATA   = 3'd2,
        WAIT_DATA = 3'd3,
        WAIT_HS   = 3'd4,
        TX_HS     = 3'd5,
        TURN      = 3'd6
    } state_e;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic logic is_token(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP);
    endfunction

    state_e             state_q,     state_d;
    state_e             turn_dest_q, turn_dest_d;
    logic               mode_q,      mode_d;      // 1 = master
    logic               dir_in_q,    dir_in_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic               frozen_q,    frozen_d;
    logic [DELAY_W-1:0] delay_q,     delay_d;
    logic [3:0]         retry_q,     retry_d;
    logic               time_out_q,  time_out_d;
    logic               retry_req_q, retry_req_d;
    logic               xfer_done_q, xfer_done_d;
    logic               xfer_err_q,  xfer_err_d;

    logic               timeout_hit;
    logic               do_retry;
    logic               hs_pid;
    logic [TIMER_W-1:0] timer_inc;

    assign timer_inc   = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 1'b1;
    assign timeout_hit = !frozen_q && (timer_q == lnk.time_threshold);
    // Master only reacts to real handshakes; a slave treats any PID as the end of its wait.
    assign hs_pid      = lnk.rx_pid_en &&
                         (mode_q ? ((lnk.rx_pid == PID_ACK) || (lnk.rx_pid == PID_NAK) ||
                                    (lnk.rx_pid == PID_STALL))
                                 : 1'b1);

    always_comb begin
        state_d     = state_q;
        turn_dest_d = turn_dest_q;
        mode_d      = mode_q;
        dir_in_d    = dir_in_q;
        timer_d     = timer_q;
        frozen_d    = frozen_q;
        delay_d     = delay_q;
        retry_d     = retry_q;
        time_out_d  = 1'b0;
        retry_req_d = 1'b0;
        xfer_done_d = 1'b0;
        xfer_err_d  = 1'b0;
        do_retry    = 1'b0;

        case (state_q)
            IDLE: begin
                if (lnk.ms) begin
                    if (lnk.tx_pid_en && is_token(lnk.tx_pid)) begin
                        state_d  = TX_TOKEN;
                        mode_d   = 1'b1;
                        dir_in_d = (lnk.tx_pid == PID_IN);
                    end
                end else if (lnk.rx_pid_en && is_token(lnk.rx_pid)) begin
                    mode_d   = 1'b0;
                    dir_in_d = (lnk.rx_pid == PID_IN);
                    if (lnk.rx_pid == PID_IN) begin
                        state_d     = TURN;
                        turn_dest_d = TX_DATA;
                        delay_d     = '0;
                    end else begin
                        state_d  = WAIT_DATA;
                        timer_d  = '0;
                        frozen_d = 1'b0;
                    end
                end
            end

            TX_TOKEN: begin
                if (lnk.tx_eop_en) begin
                    if (dir_in_q) begin
                        state_d     = TURN;
                        turn_dest_d = WAIT_DATA;
                        delay_d     = '0;
                    end else begin
                        state_d = TX_DATA;
                    end
                end
            end

            TX_DATA: begin
                if (lnk.tx_eop_en) begin
                    state_d     = TURN;
                    turn_dest_d = WAIT_HS;
                    delay_d     = '0;
                end
            end

            WAIT_DATA: begin
                // End of packet wins over both the freeze and the timeout.
                if (lnk.rx_eop_en) begin
                    state_d     = TURN;
                    turn_dest_d = TX_HS;
                    delay_d     = '0;
                end else if (lnk.rx_sop_en) begin
                    timer_d  = '0;
                    frozen_d = 1'b1;
                end else if (timeout_hit) begin
                    time_out_d = 1'b1;
                    if (mode_q) do_retry = 1'b1;
                    else        state_d  = IDLE;
                end else if (!frozen_q) begin
                    timer_d = timer_inc;
                end
            end

            WAIT_HS: begin
                if (hs_pid) begin
                    state_d = IDLE;
                    if (lnk.rx_pid == PID_ACK) begin
                        xfer_done_d = 1'b1;
                        if (mode_q) retry_d = '0;
                    end else if (mode_q && (lnk.rx_pid == PID_NAK)) begin
                        do_retry = 1'b1;
                    end else if (mode_q) begin
                        xfer_err_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    time_out_d = 1'b1;
                    if (mode_q) do_retry = 1'b1;
                    else        state_d  = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            TX_HS: begin
                if (lnk.tx_eop_en) begin
                    state_d     = IDLE;
                    xfer_done_d = 1'b1;
                    if (mode_q) retry_d = '0;
                end
            end

            TURN: begin
                if (delay_q == lnk.delay_threshold) begin
                    state_d  = turn_dest_q;
                    timer_d  = '0;
                    frozen_d = 1'b0;
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (do_retry) begin
            state_d = IDLE;
            if (retry_q < 4'(MAX_RETRY)) begin
                retry_d     = retry_q + 4'd1;
                retry_req_d = 1'b1;
            end else begin
                retry_d    = '0;
                xfer_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            turn_dest_q <= IDLE;
            mode_q      <= 1'b0;
            dir_in_q    <= 1'b0;
            timer_q     <= '0;
            frozen_q    <= 1'b0;
            delay_q     <= '0;
            retry_q     <= '0;
            time_out_q  <= 1'b0;
            retry_req_q <= 1'b0;
            xfer_done_q <= 1'b0;
            xfer_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_dest_q <= turn_dest_d;
            mode_q      <= mode_d;
            dir_in_q    <= dir_in_d;
            timer_q     <= timer_d;
            frozen_q    <= frozen_d;
            delay_q     <= delay_d;
            retry_q     <= retry_d;
            time_out_q  <= time_out_d;
            retry_req_q <= retry_req_d;
            xfer_done_q <= xfer_done_d;
            xfer_err_q  <= xfer_err_d;
        end
    end

    // In IDLE the drive enable follows live ms so the bus is owned as soon as a master is selected.
    always_comb begin
        case (state_q)
            IDLE:                     lnk.d_oe = lnk.ms;
            TX_TOKEN, TX_DATA, TX_HS: lnk.d_oe = 1'b1;
            default:                  lnk.d_oe = 1'b0;
        endcase
    end

    assign lnk.state_o    = state_q;
    assign lnk.tx_data_on = (state_q == TX_DATA);
    assign lnk.rx_data_on = (state_q == WAIT_DATA);
    assign lnk.rx_hs_on   = (state_q == WAIT_HS);
    assign lnk.time_out   = time_out_q;
    assign lnk.retry_req  = retry_req_q;
    assign lnk.xfer_done  = xfer_done_q;
    assign lnk.xfer_err   = xfer_err_q;
endmodule

// File: tb/tb_usb_link_fsm.sv
// Directed bench for usb_link_fsm; pulse outputs are matched against a queue of expected events.
`timescale 1ns/1ps
module tb_usb_link_fsm;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    // Event code bits: {time_out, retry_req, xfer_done, xfer_err}
    localparam logic [3:0] EV_DONE   = 4'b0010;
    localparam logic [3:0] EV_ERR    = 4'b0001;
    localparam logic [3:0] EV_TO_RTY = 4'b1100;
    localparam logic [3:0] EV_TO_ERR = 4'b1001;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   n;
    logic [3:0] exp_q[$];
    logic [3:0] ev;

    usb_link_if #(.TIMER_W(16), .DELAY_W(6)) lnk ();

    usb_link_fsm #(.TIMER_W(16), .DELAY_W(6), .MAX_RETRY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lnk   (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Every cycle with any event output high must match the next queued expectation.
    always @(negedge clk) begin
        ev = {lnk.time_out, lnk.retry_req, lnk.xfer_done, lnk.xfer_err};
        if (ev !== 4'h0) begin
            if (exp_q.size() > 0) check("pulse_event", ev, exp_q.pop_front());
            else                  check("unexpected_pulse", ev, 4'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_pid_pulse(input logic [3:0] p);
        lnk.tx_pid_en = 1'b1; lnk.tx_pid = p; tick(); lnk.tx_pid_en = 1'b0;
    endtask
    task automatic rx_pid_pulse(input logic [3:0] p);
        lnk.rx_pid_en = 1'b1; lnk.rx_pid = p; tick(); lnk.rx_pid_en = 1'b0;
    endtask
    task automatic tx_eop_pulse();
        lnk.tx_eop_en = 1'b1; tick(); lnk.tx_eop_en = 1'b0;
    endtask
    task automatic rx_eop_pulse();
        lnk.rx_eop_en = 1'b1; tick(); lnk.rx_eop_en = 1'b0;
    endtask
    task automatic rx_sop_pulse();
        lnk.rx_sop_en = 1'b1; tick(); lnk.rx_sop_en = 1'b0;
    endtask

    task automatic wait_turn(output int cyc, output logic doe_seen);
        cyc = 0;
        doe_seen = 1'b0;
        while (lnk.state_o == 3'd6 && cyc < 64) begin
            doe_seen = doe_seen | lnk.d_oe;
            cyc++;
            tick();
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic doe;
        rst_n = 1'b0;
        lnk.ms = 1'b1;
        lnk.rx_pid_en = 1'b0; lnk.rx_pid = 4'h0; lnk.rx_sop_en = 1'b0; lnk.rx_eop_en = 1'b0;
        lnk.tx_pid_en = 1'b0; lnk.tx_pid = 4'h0; lnk.tx_eop_en = 1'b0;
        lnk.time_threshold = 16'd100;
        lnk.delay_threshold = 6'd2;
        #12;
        check("rst_state", lnk.state_o, 3'd0);
        check("rst_doe_ms1", lnk.d_oe, 1'b1);
        check("rst_enables", {lnk.rx_data_on, lnk.rx_hs_on, lnk.tx_data_on}, 3'b000);
        check("rst_pulses", {lnk.time_out, lnk.retry_req, lnk.xfer_done, lnk.xfer_err}, 4'h0);
        lnk.ms = 1'b0;
        #1;
        check("rst_doe_ms0", lnk.d_oe, 1'b0);
        lnk.ms = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Master OUT with a 3-cycle turnaround and ACK
        tx_pid_pulse(PID_OUT);
        check("m_out_token", lnk.state_o, 3'd1);
        check("m_out_token_doe", lnk.d_oe, 1'b1);
        tx_eop_pulse();
        check("m_out_txdata", {lnk.state_o, lnk.tx_data_on, lnk.d_oe}, {3'd2, 2'b11});
        tx_pid_pulse(PID_IN);
        check("m_ignore_txpid", lnk.state_o, 3'd2);
        tx_eop_pulse();
        wait_turn(n, doe);
        check("m_out_turn_len", n, 3);
        check("m_out_turn_doe", doe, 1'b0);
        check("m_out_waiths", {lnk.state_o, lnk.rx_hs_on}, {3'd4, 1'b1});
        rx_eop_pulse();
        check("m_ignore_rxeop", lnk.state_o, 3'd4);
        exp_q.push_back(EV_DONE);
        rx_pid_pulse(PID_ACK);
        check("m_out_done", {lnk.state_o, lnk.xfer_done}, {3'd0, 1'b1});
        tick();
        check("m_out_done_1cyc", lnk.xfer_done, 1'b0);

        // Master IN: data received, then handshake transmitted
        tx_pid_pulse(PID_IN);
        tx_eop_pulse();
        wait_turn(n, doe);
        check("m_in_waitdata", {lnk.state_o, lnk.rx_data_on, lnk.d_oe}, {3'd3, 2'b10});
        rx_sop_pulse();
        repeat (3) tick();
        rx_eop_pulse();
        wait_turn(n, doe);
        check("m_in_turn_len", n, 3);
        check("m_in_txhs", {lnk.state_o, lnk.d_oe}, {3'd5, 1'b1});
        exp_q.push_back(EV_DONE);
        tx_eop_pulse();
        check("m_in_done", {lnk.state_o, lnk.xfer_done}, {3'd0, 1'b1});

        // Master OUT timeouts: three retries, then the fourth failure errors out
        lnk.time_threshold = 16'd10;
        for (int k = 0; k < 4; k++) begin
            tx_pid_pulse(PID_OUT);
            tx_eop_pulse();
            tx_eop_pulse();
            wait_turn(n, doe);
            check("m_to_waiths", lnk.state_o, 3'd4);
            exp_q.push_back(k < 3 ? EV_TO_RTY : EV_TO_ERR);
            n = 0;
            while (lnk.state_o == 3'd4 && n < 50) begin
                tick();
                n++;
            end
            // Timer reaches 10 ten cycles after entry; the pulse registers one cycle later.
            check("m_to_latency", n, 11);
            check("m_to_pulses", {lnk.state_o, lnk.time_out, lnk.retry_req, lnk.xfer_err},
                  {3'd0, 1'b1, (k < 3), (k == 3)});
        end
        tick();

        // Slave IN with 1-cycle turnaround, STALL ends silently
        lnk.ms = 1'b0;
        lnk.delay_threshold = 6'd0;
        #1;
        check("s_idle_doe", lnk.d_oe, 1'b0);
        rx_pid_pulse(PID_IN);
        check("s_in_turn", {lnk.state_o, lnk.d_oe}, {3'd6, 1'b0});
        wait_turn(n, doe);
        check("s_in_turn_len", n, 1);
        check("s_in_txdata", {lnk.state_o, lnk.tx_data_on, lnk.d_oe}, {3'd2, 2'b11});
        tx_eop_pulse();
        wait_turn(n, doe);
        check("s_in_waiths", lnk.state_o, 3'd4);
        rx_pid_pulse(PID_STALL);
        check("s_in_stall", {lnk.state_o, lnk.xfer_done, lnk.xfer_err}, {3'd0, 2'b00});

        // Slave OUT: timer frozen by rx_sop_en well before a late rx_eop_en
        lnk.time_threshold = 16'd5;
        lnk.delay_threshold = 6'd2;
        rx_pid_pulse(PID_OUT);
        check("s_out_waitdata", {lnk.state_o, lnk.rx_data_on}, {3'd3, 1'b1});
        tick();
        tick();
        rx_sop_pulse();
        repeat (36) tick();
        check("s_out_still_waiting", lnk.state_o, 3'd3);
        rx_eop_pulse();
        wait_turn(n, doe);
        check("s_out_txhs", {lnk.state_o, lnk.d_oe}, {3'd5, 1'b1});
        exp_q.push_back(EV_DONE);
        tx_eop_pulse();
        check("s_out_done", {lnk.state_o, lnk.xfer_done}, {3'd0, 1'b1});

        // Reset in WAIT_HS aborts silently
        lnk.ms = 1'b1;
        lnk.time_threshold = 16'd100;
        tx_pid_pulse(PID_OUT);
        tx_eop_pulse();
        tx_eop_pulse();
        wait_turn(n, doe);
        check("r_waiths", lnk.state_o, 3'd4);
        rst_n = 1'b0;
        #1;
        check("r_async_state", lnk.state_o, 3'd0);
        check("r_async_outs", {lnk.rx_data_on, lnk.rx_hs_on, lnk.tx_data_on, lnk.d_oe},
              4'b0001);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("r_post_idle", lnk.state_o, 3'd0);
        tx_pid_pulse(PID_OUT);
        check("r_resume", lnk.state_o, 3'd1);

        wait_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
